// File: rtl/program_loader_if.sv
// Host byte stream and instruction memory write bus of the program loader.
interface program_loader_if;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  // Host side: drives the byte stream, observes status and the memory bus.
  modport master (
    output start, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
  );

  // Loader side.
  modport slave (
    input  start, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
  );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory
// and keeps the core held in reset until a complete, valid image is present.
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input logic              clk,
  input logic              rst,
  program_loader_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_lo_q;
  logic [15:0] count_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_idx_q;
  logic [31:0] word_q;
  logic        error_q;

  logic        rdy;
  logic        accept;
  logic [15:0] len_full;
  logic        oversize;
  logic        last_word;

  assign rdy       = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
  assign accept    = bus.in_valid && rdy;
  assign len_full  = {bus.in_data, len_lo_q};
  assign oversize  = 32'(len_full) > MAX_WORDS;
  assign last_word = (17'(word_idx_q) + 17'd1) == 17'(count_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; start only matters when no load is running.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (bus.start) state_d = StLenLo;
      StLenLo:        if (accept) state_d = StLenHi;
      StLenHi: begin
        if (accept) state_d = (len_full == 16'd0 || oversize) ? StDone : StData;
      end
      StData:         if (accept && byte_idx_q == 2'd3) state_d = StWrite;
      StWrite:        state_d = last_word ? StDone : StData;
      default:        state_d = StIdle;
    endcase
  end

  // Length capture, word assembly and write indexing.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo_q   <= 8'd0;
      count_q    <= 16'd0;
      word_idx_q <= 16'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      error_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            error_q    <= 1'b0;
            word_idx_q <= 16'd0;
            byte_idx_q <= 2'd0;
          end
        end
        StLenLo: if (accept) len_lo_q <= bus.in_data;
        StLenHi: begin
          if (accept) begin
            count_q <= len_full;
            error_q <= oversize;
          end
        end
        StData: begin
          if (accept) begin
            word_q[{byte_idx_q, 3'b000} +: 8] <= bus.in_data;
            // Wraps to 0 on the 4th byte, ready for the next word.
            byte_idx_q <= byte_idx_q + 2'd1;
          end
        end
        StWrite: word_idx_q <= word_idx_q + 16'd1;
        default: ;
      endcase
    end
  end

  // Outputs; the memory bus is forced to zero outside the write cycle.
  always_comb begin
    bus.in_ready  = rdy;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    unique case (state_q)
      StLenLo, StLenHi, StData: bus.busy = 1'b1;
      StWrite: begin
        bus.busy      = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
        bus.mem_wdata = word_q;
      end
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
    bus.error    = error_q;
    bus.cpu_hold = !((state_q == StDone) && !error_q);
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: two loaders (base 0 and base 0x100) share one byte stream;
// writes are collected and compared against the expected image of each load.
module tb_program_loader;

  localparam int unsigned MaxWords = 1024;
  localparam logic [31:0] Base1    = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] count;
    int          gap_pct;
    bit          start_mid;
    bit          exp_error;
    bit          exp_hold;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;

  int checks = 0;
  int errors = 0;

  wr_t        got0[$];
  wr_t        got1[$];
  logic [7:0] payload[$];

  program_loader_if if0 ();
  program_loader_if if1 ();

  assign if0.start    = start;
  assign if0.in_valid = in_valid;
  assign if0.in_data  = in_data;
  assign if1.start    = start;
  assign if1.in_valid = in_valid;
  assign if1.in_data  = in_data;

  program_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(MaxWords)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  program_loader #(.BASE_ADDR(Base1), .MAX_WORDS(MaxWords)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  always #5 clk = ~clk;

  // Collect every write; when not writing, the memory bus must read zero.
  always @(negedge clk) begin
    if (if0.mem_we) got0.push_back({if0.mem_addr, if0.mem_wdata});
    if (if1.mem_we) got1.push_back({if1.mem_addr, if1.mem_wdata});
    if (!if0.mem_we && !if1.mem_we) begin
      checks++;
      if (if0.mem_addr != 0 || if0.mem_wdata != 0 || if1.mem_addr != 0 || if1.mem_wdata != 0) begin
        errors++;
        $display("FAIL idle_bus: addr %h/%h wdata %h/%h, required all zero",
                 if0.mem_addr, if1.mem_addr, if0.mem_wdata, if1.mem_wdata);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference rule: a load writes count words only when 1 <= count <= MAX_WORDS.
  function automatic int exp_words(input logic [15:0] c);
    return (c != 16'd0 && 32'(c) <= MaxWords) ? int'(c) : 0;
  endfunction

  task automatic check_writes(input string tag, input logic [31:0] base, input int nwords,
                              input wr_t got[$]);
    logic [31:0] ea, ew;
    chk({tag, "_nwrites"}, 64'(got.size()), 64'(nwords));
    for (int i = 0; i < nwords && i < got.size(); i++) begin
      ea = base + 32'(4 * i);
      ew = {payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]};
      chk({tag, "_write"}, 64'(got[i]), {ea, ew});
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, 64'({if0.in_ready, if1.in_ready}), 64'(0));
    chk({tag, "_mem_we"},   64'({if0.mem_we, if1.mem_we}), 64'(0));
    chk({tag, "_mem_addr"}, {if0.mem_addr, if1.mem_addr}, 64'(0));
    chk({tag, "_wdata"},    {if0.mem_wdata, if1.mem_wdata}, 64'(0));
    chk({tag, "_busy"},     64'({if0.busy, if1.busy}), 64'(0));
    chk({tag, "_done"},     64'({if0.done, if1.done}), 64'(0));
    chk({tag, "_error"},    64'({if0.error, if1.error}), 64'(0));
    chk({tag, "_cpu_hold"}, 64'({if0.cpu_hold, if1.cpu_hold}), 64'(2'b11));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", 64'({if0.busy, if1.busy}), 64'(2'b11));
  endtask

  // Offer one byte, with optional idle gaps and spurious start pulses, until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit start_mid);
    bit acc;
    bit taken = 1'b0;
    if ($urandom_range(99) < gap_pct) begin
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        start    = start_mid && ($urandom_range(1) == 1);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    start    = start_mid && ($urandom_range(1) == 1);
    for (int t = 0; t < 20 && !taken; t++) begin
      acc = if0.in_ready;
      @(posedge clk);
      if (acc) taken = 1'b1;
      else @(negedge clk);
    end
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
    if (!taken) begin
      errors++;
      $display("FAIL byte_accept: byte %h not accepted, required within 20 cycles", b);
    end
  endtask

  task automatic run_load(input logic [15:0] cnt, input int gap_pct, input bit start_mid);
    got0.delete();
    got1.delete();
    pulse_start();
    send_byte(cnt[7:0], gap_pct, start_mid);
    send_byte(cnt[15:8], gap_pct, start_mid);
    if (exp_words(cnt) > 0)
      foreach (payload[i]) send_byte(payload[i], gap_pct, start_mid);
  endtask

  task automatic finish_load(input string tag, input logic [15:0] cnt, input bit exp_err,
                             input bit exp_hold);
    int t = 0;
    @(negedge clk);
    while (!if0.done && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"},     64'({if0.done, if1.done}), 64'(2'b11));
    chk({tag, "_error"},    64'({if0.error, if1.error}), 64'({exp_err, exp_err}));
    chk({tag, "_cpu_hold"}, 64'({if0.cpu_hold, if1.cpu_hold}), 64'({exp_hold, exp_hold}));
    chk({tag, "_busy"},     64'({if0.busy, if1.busy}), 64'(0));
    chk({tag, "_in_ready"}, 64'({if0.in_ready, if1.in_ready}), 64'(0));
    check_writes({tag, "_d0"}, 32'h0, exp_words(cnt), got0);
    check_writes({tag, "_d1"}, Base1, exp_words(cnt), got1);
  endtask

  task automatic random_payload(input logic [15:0] cnt);
    payload.delete();
    for (int i = 0; i < 4 * exp_words(cnt); i++) payload.push_back(8'($urandom));
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'd1,     0,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'd3,     40, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'd0,     0,  1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'd1025,  0,  1'b0, 1'b1, 1'b1};
    vecs[4] = '{16'd1024,  10, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'd5,     60, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF,  20, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{16'd1,     50, 1'b1, 1'b0, 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // Two-word image at base 0 (and mirrored at 0x100).
    payload = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    run_load(16'd2, 0, 1'b0);
    finish_load("two_words", 16'd2, 1'b0, 1'b0);
    if (got0.size() == 2) begin
      chk("two_words_w0", 64'(got0[0]), {32'h0, 32'h0010_0513});
      chk("two_words_w1", 64'(got0[1]), {32'h4, 32'h0020_0593});
    end

    // Single word: byte order and relocated base.
    payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(16'd1, 0, 1'b0);
    finish_load("one_word", 16'd1, 1'b0, 1'b0);
    if (got1.size() == 1) chk("one_word_base", 64'(got1[0]), {32'h100, 32'hDDCC_BBAA});

    foreach (vecs[i]) begin
      random_payload(vecs[i].count);
      run_load(vecs[i].count, vecs[i].gap_pct, vecs[i].start_mid);
      finish_load($sformatf("vec%0d", i), vecs[i].count, vecs[i].exp_error, vecs[i].exp_hold);
    end

    // Reset after two data bytes, with start held alongside rst.
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    got0.delete();
    got1.delete();
    pulse_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 check_idle("mid_reset");
    @(negedge clk);
    chk("mid_reset_nwrites", 64'(got0.size() + got1.size()), 64'(0));
    rst   = 1'b0;
    start = 1'b0;
    random_payload(16'd1);
    run_load(16'd1, 30, 1'b1);
    finish_load("after_reset", 16'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
